// File: rtl/signed_add_pkg.sv
// Shared types and constants for the byte-serial signed adder.
// Optional subtract mode is enabled with the SIGNED_ADD_SUB_EN macro.
package signed_add_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Index width, never narrower than one bit so NBYTES=1 still has a legal counter.
   function automatic int unsigned idx_w(input int unsigned nbytes);
      return (nbytes > 1) ? $clog2(nbytes) : 1;
   endfunction

endpackage

// File: rtl/signed_add_byte_slice.sv
// Combinational 8-bit add slice exposing the carry into bit 7 so the
// sequencer can form signed overflow by the carry method.
module signed_add_byte_slice
   import signed_add_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout,
   output logic              ovf
);

   logic [BYTE_W-2:0] low;
   logic              c7;
   logic              top;

   always_comb begin
      {c7, low}   = {1'b0, a[BYTE_W-2:0]} + {1'b0, b[BYTE_W-2:0]} + {{(BYTE_W-1){1'b0}}, cin};
      {cout, top} = {1'b0, a[BYTE_W-1]} + {1'b0, b[BYTE_W-1]} + {1'b0, c7};
      sum         = {top, low};
      ovf         = c7 ^ cout;
   end

endmodule

// File: rtl/signed_add_sequencer.sv
// Wide two's-complement adder that reuses one byte slice over NBYTES cycles, LSB first.
// Define SIGNED_ADD_SUB_EN to add the in_sub port (A-B via inverted B and carry-in of 1).
module signed_add_sequencer
   import signed_add_pkg::*;
#(
   parameter int unsigned NBYTES = 4
) (
   input  logic                       clk,
   input  logic                       areset,
   input  logic                       in_valid,
   output logic                       in_ready,
`ifdef SIGNED_ADD_SUB_EN
   input  logic                       in_sub,
`endif
   input  logic [NBYTES*BYTE_W-1:0]   in_a,
   input  logic [NBYTES*BYTE_W-1:0]   in_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NBYTES*BYTE_W-1:0]   out_sum,
   output logic                       out_overflow,
   output logic                       out_carry
);

   localparam int unsigned W    = NBYTES * BYTE_W;
   localparam int unsigned IW   = idx_w(NBYTES);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   state_t            state_q, state_d;
   logic [W-1:0]      a_q, b_q, sum_q, sum_d;
   logic [IW-1:0]     idx_q;
   logic              carry_q, ovf_q, cout_q;
   logic [BYTE_W-1:0] a_byte, b_byte, s_byte;
   logic              s_cout, s_ovf;
   logic              accept, last, init_cin;
   logic [W-1:0]      b_in;

`ifdef SIGNED_ADD_SUB_EN
   // Subtraction is folded in at latch time: store ~B and seed the carry with 1.
   assign init_cin = in_sub;
   assign b_in     = in_sub ? ~in_b : in_b;
`else
   assign init_cin = 1'b0;
   assign b_in     = in_b;
`endif

   assign accept = in_valid && in_ready;
   assign last   = (idx_q == LAST);

   always_comb begin
      a_byte = '0;
      b_byte = '0;
      sum_d  = sum_q;
      for (int i = 0; i < int'(NBYTES); i++) begin
         if (idx_q == IW'(i)) begin
            a_byte                      = a_q[i*BYTE_W +: BYTE_W];
            b_byte                      = b_q[i*BYTE_W +: BYTE_W];
            sum_d[i*BYTE_W +: BYTE_W]   = s_byte;
         end
      end
   end

   signed_add_byte_slice u_slice (
      .a    (a_byte),
      .b    (b_byte),
      .cin  (carry_q),
      .sum  (s_byte),
      .cout (s_cout),
      .ovf  (s_ovf)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)    state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         a_q     <= in_a;
         b_q     <= b_in;
         idx_q   <= '0;
         carry_q <= init_cin;
      end else if (state_q == RUN) begin
         sum_q   <= sum_d;
         carry_q <= s_cout;
         idx_q   <= idx_q + 1'b1;
         if (last) begin
            ovf_q  <= s_ovf;
            cout_q <= s_cout;
         end
      end
   end

   assign out_sum      = sum_q;
   assign out_overflow = ovf_q;
   assign out_carry    = cout_q;

endmodule
